// File: rtl/mccp_pkg.sv
// Shared definitions for the tag allocator: FSM state encoding and default sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mccp_pkg;

  localparam int TAG_WIDTH_DEF = 32;
  localparam int TAG_DEPTH_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    ALLOC  = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/tag_table.sv
// Tag storage: 2**DEPTH tags with valid bits, a compare port, a free-entry finder and a registered reverse read.
// Latency: compare/free results are combinational; rd_data is valid one cycle after rd_addr is sampled.
// Backpressure: none; the write and flush ports are always accepted.
//
// Ports: clk/rst_n clock and async active-low reset; flush clears all valid bits (tags keep their values);
//        we/waddr/wdata write a tag and mark it valid; key is the tag being searched;
//        with TAG_ALLOC_PARALLEL_EN: match_any/match_idx report the lowest valid entry equal to key;
//        without it: cmp_idx selects one entry and cmp_hit reports whether it is valid and equal to key;
//        free_any/free_idx give the lowest invalid entry; rd_addr/rd_data form the reverse read port.
module tag_table
  import mccp_pkg::*;
#(
  parameter int WIDTH = TAG_WIDTH_DEF,
  parameter int DEPTH = TAG_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             we,
  input  logic [DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] key,
`ifdef TAG_ALLOC_PARALLEL_EN
  output logic             match_any,
  output logic [DEPTH-1:0] match_idx,
`else
  input  logic [DEPTH-1:0] cmp_idx,
  output logic             cmp_hit,
`endif
  output logic             free_any,
  output logic [DEPTH-1:0] free_idx,
  input  logic [DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int N = 1 << DEPTH;

  logic [WIDTH-1:0] tags [N];
  logic [N-1:0]     valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) tags[i] <= '0;
      valid   <= '0;
      rd_data <= '0;
    end else begin
      // Read samples the array before this edge's write lands, so a
      // same-cycle write to rd_addr returns the old tag.
      rd_data <= tags[rd_addr];
      if (we) tags[waddr] <= wdata;
      if (flush)   valid        <= '0;
      else if (we) valid[waddr] <= 1'b1;
    end
  end

`ifdef TAG_ALLOC_PARALLEL_EN
  // Scan high to low so the lowest matching index wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == key)) begin
        match_any = 1'b1;
        match_idx = DEPTH'(i);
      end
    end
  end
`else
  assign cmp_hit = valid[cmp_idx] && (tags[cmp_idx] == key);
`endif

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_any = 1'b1;
        free_idx = DEPTH'(i);
      end
    end
  end

endmodule

// File: rtl/tag_allocator.sv
// Tag allocator: looks a tag up in the table, returns its index on a hit, otherwise allocates an entry (evicting round-robin when full).
// Latency: sequential search hit at T+2+k, miss at T+2+2**DEPTH; with TAG_ALLOC_PARALLEL_EN hit at T+2, miss at T+3.
// Backpressure: one request in flight; req_ready is low until the response is taken with rsp_valid&&rsp_ready.
//
// Ports: clk/rst_n clock and async active-low reset; req_valid/req_ready/req_data request handshake;
//        rsp_valid/rsp_ready/rsp_idx/rsp_hit/rsp_evict response handshake; flush invalidates the table
//        and aborts any request; rd_addr/rd_data registered reverse read (index -> tag).
// Build option: define TAG_ALLOC_PARALLEL_EN to compare all entries in a single SEARCH cycle.
module tag_allocator
  import mccp_pkg::*;
#(
  parameter int WIDTH = TAG_WIDTH_DEF,
  parameter int DEPTH = TAG_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DEPTH-1:0] rsp_idx,
  output logic             rsp_hit,
  output logic             rsp_evict,
  input  logic             flush,
  input  logic [DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] req_q, req_nxt;
  logic [DEPTH-1:0] victim, victim_nxt;
  logic [DEPTH-1:0] idx_q, idx_nxt;
  logic             hit_q, hit_nxt;
  logic             evict_q, evict_nxt;

  logic             tbl_we;
  logic [DEPTH-1:0] tbl_waddr;
  logic             free_any;
  logic [DEPTH-1:0] free_idx;

`ifdef TAG_ALLOC_PARALLEL_EN
  logic             match_any;
  logic [DEPTH-1:0] match_idx;
`else
  localparam logic [DEPTH-1:0] LAST = '1;
  logic [DEPTH-1:0] cnt, cnt_nxt;
  logic             cmp_hit;
`endif

  tag_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .we        (tbl_we),
    .waddr     (tbl_waddr),
    .wdata     (req_q),
    .key       (req_q),
`ifdef TAG_ALLOC_PARALLEL_EN
    .match_any (match_any),
    .match_idx (match_idx),
`else
    .cmp_idx   (cnt),
    .cmp_hit   (cmp_hit),
`endif
    .free_any  (free_any),
    .free_idx  (free_idx),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_q   <= '0;
      victim  <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      evict_q <= 1'b0;
`ifndef TAG_ALLOC_PARALLEL_EN
      cnt     <= '0;
`endif
    end else begin
      state   <= state_nxt;
      req_q   <= req_nxt;
      victim  <= victim_nxt;
      idx_q   <= idx_nxt;
      hit_q   <= hit_nxt;
      evict_q <= evict_nxt;
`ifndef TAG_ALLOC_PARALLEL_EN
      cnt     <= cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    req_nxt    = req_q;
    victim_nxt = victim;
    idx_nxt    = idx_q;
    hit_nxt    = hit_q;
    evict_nxt  = evict_q;
    tbl_we     = 1'b0;
    // Allocation target: lowest free entry, else the round-robin victim.
    tbl_waddr  = free_any ? free_idx : victim;
`ifndef TAG_ALLOC_PARALLEL_EN
    cnt_nxt    = cnt;
`endif

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = SEARCH;
          req_nxt   = req_data;
`ifndef TAG_ALLOC_PARALLEL_EN
          cnt_nxt   = '0;
`endif
        end
      end
      SEARCH: begin
`ifdef TAG_ALLOC_PARALLEL_EN
        if (match_any) begin
          state_nxt = RESP;
          idx_nxt   = match_idx;
          hit_nxt   = 1'b1;
          evict_nxt = 1'b0;
        end else begin
          state_nxt = ALLOC;
        end
`else
        if (cmp_hit) begin
          state_nxt = RESP;
          idx_nxt   = cnt;
          hit_nxt   = 1'b1;
          evict_nxt = 1'b0;
        end else if (cnt == LAST) begin
          state_nxt = ALLOC;
        end else begin
          cnt_nxt = cnt + DEPTH'(1);
        end
`endif
      end
      ALLOC: begin
        tbl_we    = 1'b1;
        state_nxt = RESP;
        idx_nxt   = tbl_waddr;
        hit_nxt   = 1'b0;
        evict_nxt = !free_any;
        if (!free_any) victim_nxt = victim + DEPTH'(1);
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Flush overrides everything: abort the request, drop any pending
    // response and suppress a same-cycle allocation write.
    if (flush) begin
      state_nxt  = IDLE;
      victim_nxt = '0;
      tbl_we     = 1'b0;
    end
  end

  assign req_ready = (state == IDLE) && !flush;
  assign rsp_valid = (state == RESP);
  assign rsp_idx   = idx_q;
  assign rsp_hit   = hit_q;
  assign rsp_evict = evict_q;

endmodule

// File: tb/tb_tag_allocator.sv
// Directed bench for tag_allocator (DEPTH=3, WIDTH=32); latencies follow TAG_ALLOC_PARALLEL_EN.
module tb_tag_allocator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [2:0]  rsp_idx;
  logic        rsp_hit;
  logic        rsp_evict;
  logic        flush = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef TAG_ALLOC_PARALLEL_EN
  localparam int MISS_LAT   = 3;
  localparam int FLUSH_SKIP = 0;
  function automatic int hit_lat(input int k); return 2; endfunction
`else
  localparam int MISS_LAT   = 10;
  localparam int FLUSH_SKIP = 2;
  function automatic int hit_lat(input int k); return 2 + k; endfunction
`endif

  tag_allocator #(.WIDTH(32), .DEPTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_idx   (rsp_idx),
    .rsp_hit   (rsp_hit),
    .rsp_evict (rsp_evict),
    .flush     (flush),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Handshake in cycle T, then report the first cycle offset with rsp_valid (-1 on timeout).
  task automatic issue(input logic [31:0] tag, output int lat, output logic [2:0] idx,
                       output logic hit, output logic ev);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1;
    req_data  = tag;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; idx = '0; hit = 1'b0; ev = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c; idx = rsp_idx; hit = rsp_hit; ev = rsp_evict;
        break;
      end
    end
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    check(name, rd_data, exp);
  endtask

  initial begin
    int         lat;
    logic [2:0] idx;
    logic       hit, ev;
    int         seen;

    // Reset
    #2 rst_n = 1'b0;
    #10;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_hit",   rsp_hit, 0);
    check("rst_rsp_evict", rsp_evict, 0);
    check("rst_rsp_idx",   rsp_idx, 0);
    check("rst_rd_data",   rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First request into an empty table
    issue(32'hAAAA0001, lat, idx, hit, ev);
    check("miss0_lat", lat, MISS_LAT);
    check("miss0_idx", idx, 0);
    check("miss0_hit", hit, 0);
    check("miss0_evict", ev, 0);

    // Fill the rest of the table
    for (int i = 1; i < 8; i++) begin
      issue(32'hAAAA0001 + 32'(i), lat, idx, hit, ev);
      check($sformatf("fill%0d_idx", i), idx, i);
      check($sformatf("fill%0d_hit_evict", i), {hit, ev}, 2'b00);
    end
    check("fill7_lat", lat, MISS_LAT);

    // Hit on entry 5
    issue(32'hAAAA0006, lat, idx, hit, ev);
    check("hit5_lat", lat, hit_lat(5));
    check("hit5_idx", idx, 5);
    check("hit5_hit", hit, 1);
    check("hit5_evict", ev, 0);

    // Table full: round-robin eviction from 0
    issue(32'hBBBB0009, lat, idx, hit, ev);
    check("ev9_idx", idx, 0);
    check("ev9_hit_evict", {hit, ev}, 2'b01);
    check("ev9_lat", lat, MISS_LAT);
    issue(32'hBBBB000A, lat, idx, hit, ev);
    check("ev10_idx", idx, 1);
    check("ev10_hit_evict", {hit, ev}, 2'b01);
    rd_check("rd0", 3'd0, 32'hBBBB0009);
    rd_check("rd1", 3'd1, 32'hBBBB000A);
    rd_check("rd7", 3'd7, 32'hAAAA0008);

    // Response backpressure on a hit to entry 2
    rsp_ready = 1'b0;
    issue(32'hAAAA0003, lat, idx, hit, ev);
    check("hold_lat", lat, hit_lat(2));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_state", i), {rsp_valid, rsp_hit, rsp_evict, req_ready}, 4'b1100);
      check($sformatf("hold%0d_idx", i), rsp_idx, 2);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("release_rsp_valid", rsp_valid, 0);
    check("release_req_ready", req_ready, 1);

    // flush blocks req_ready combinationally
    flush = 1'b1;
    #1 check("flush_req_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;

    // Refill entries 0..1 are still valid after that flush? No: flush cleared all.
    // Flush during search of a request for a stored tag
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = 32'hAAAA0008;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < FLUSH_SKIP; i++) @(posedge clk);
    if (FLUSH_SKIP > 0) #1;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("flush_no_rsp", seen, 0);

    // Prior tag now misses and lands in entry 0 without eviction
    issue(32'hAAAA0003, lat, idx, hit, ev);
    check("postflush_lat", lat, MISS_LAT);
    check("postflush_idx", idx, 0);
    check("postflush_hit_evict", {hit, ev}, 2'b00);
    rd_check("rd7_invalid", 3'd7, 32'hAAAA0008);
    issue(32'hCCCC0001, lat, idx, hit, ev);
    check("postflush2_idx", idx, 1);
    check("postflush2_hit_evict", {hit, ev}, 2'b00);

    // Reset mid-search drops the request
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = 32'hAAAA0003;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("midrst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", req_ready, 1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    rd_check("midrst_rd7", 3'd7, 32'h0);
    issue(32'hAAAA0003, lat, idx, hit, ev);
    check("midrst_miss_idx", idx, 0);
    check("midrst_miss_hit_evict", {hit, ev}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
